// File: rtl/in_port_ctrl.sv
// in_port_ctrl: sequences CPU IN reads against the input mux.
// Synchronises switches, synchronises and debounces buttons, keeps sticky
// press flags, runs a free-running counter port and stalls the CPU until
// the requested port has been captured.
module in_port_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] PRESCALE        = 16'd1,
    parameter logic        BLOCKING_BTN    = 1'b1,
    parameter logic [31:0] TIMEOUT         = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw_raw,
    input  logic [4:0]  btn_raw,
    input  logic        in_req,
    input  logic [3:0]  port_sel,
    output logic [15:0] sw_sync,
    output logic [4:0]  btn_db,
    output logic [15:0] counter,
    output logic        in_mux_en,
    output logic        in_busy,
    output logic        in_done,
    output logic        in_timeout
);

    localparam int unsigned NUM_BTN  = 5;
    localparam int unsigned BTNC_IDX = 0;
    localparam int unsigned BTNR_IDX = 3;

    localparam logic [3:0]  PORT_BTNR = 4'd1;
    localparam logic [3:0]  PORT_BTNC = 4'd2;
    localparam logic [3:0]  PORT_LAST = 4'd3;

    // A zero parameter behaves like 1 rather than underflowing.
    localparam logic [15:0] DB_LAST  = (DEBOUNCE_CYCLES == 16'd0) ? 16'd0 : DEBOUNCE_CYCLES - 16'd1;
    localparam logic [15:0] PRE_LAST = (PRESCALE == 16'd0) ? 16'd0 : PRESCALE - 16'd1;
    localparam logic [31:0] TO_LAST  = TIMEOUT - 32'd1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BTN = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [3:0]   port_q, port_nxt;
    logic [31:0]  wait_cnt, wait_nxt;
    logic         timeout_nxt;

    logic [15:0]  sw_meta;
    logic [4:0]   btn_meta, btn_sync;
    logic [15:0]  db_cnt     [NUM_BTN];
    logic [15:0]  db_cnt_nxt [NUM_BTN];
    logic [4:0]   db_nxt;
    logic [4:0]   press, press_clr, press_rise;
    logic [15:0]  prescale_cnt;

    // Two-flop synchronisers for switches and buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw_raw;
            sw_sync  <= sw_meta;
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    // Debounce: stable level follows sync only after DEBOUNCE_CYCLES differing clocks.
    always_comb begin
        db_nxt = btn_db;
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_nxt[i] = 16'd0;
            if (btn_sync[i] != btn_db[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    db_nxt[i] = btn_sync[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= 16'd0;
            end
        end else begin
            btn_db <= db_nxt;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
            end
        end
    end

    // Press flags: set on debounced rise, cleared by a capture of that port; set wins.
    always_comb begin
        press_rise = db_nxt & ~btn_db;
        press_clr  = '0;
        if (state == CAPTURE) begin
            press_clr[BTNR_IDX] = (port_q == PORT_BTNR);
            press_clr[BTNC_IDX] = (port_q == PORT_BTNC);
        end
    end

    // Press flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press <= '0;
        end else begin
            press <= (press & ~press_clr) | press_rise;
        end
    end

    // Free-running counter advanced on each prescaler wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_cnt <= 16'd0;
            counter      <= 16'd0;
        end else if (prescale_cnt == PRE_LAST) begin
            prescale_cnt <= 16'd0;
            counter      <= counter + 16'd1;
        end else begin
            prescale_cnt <= prescale_cnt + 16'd1;
        end
    end

    // Next-state logic for the IN sequencer.
    always_comb begin
        state_nxt   = state;
        port_nxt    = port_q;
        wait_nxt    = wait_cnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (in_req) begin
                    port_nxt = port_sel;
                    if (BLOCKING_BTN &&
                        (((port_sel == PORT_BTNR) && !press[BTNR_IDX]) ||
                         ((port_sel == PORT_BTNC) && !press[BTNC_IDX]))) begin
                        state_nxt = WAIT_BTN;
                        wait_nxt  = 32'd0;
                    end else begin
                        state_nxt = CAPTURE;
                    end
                end
            end
            WAIT_BTN: begin
                if (((port_q == PORT_BTNR) && press[BTNR_IDX]) ||
                    ((port_q == PORT_BTNC) && press[BTNC_IDX])) begin
                    state_nxt = CAPTURE;
                end else if ((TIMEOUT != 32'd0) && (wait_cnt == TO_LAST)) begin
                    state_nxt   = CAPTURE;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 32'd1;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            port_q     <= 4'd0;
            wait_cnt   <= 32'd0;
            in_done    <= 1'b0;
            in_mux_en  <= 1'b0;
            in_busy    <= 1'b0;
            in_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            port_q     <= port_nxt;
            wait_cnt   <= wait_nxt;
            in_done    <= (state_nxt == CAPTURE);
            in_mux_en  <= (state_nxt == CAPTURE) && (port_nxt <= PORT_LAST);
            in_busy    <= (state_nxt != IDLE);
            in_timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_in_port_ctrl.sv
// Directed bench for in_port_ctrl: main instance (DEBOUNCE 4, PRESCALE 2,
// no timeout) and a second instance (PRESCALE 1, TIMEOUT 10).
module tb_in_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw_raw = '0;
    logic [4:0]  btn_raw = '0;
    logic        in_req = 1'b0;
    logic [3:0]  port_sel = '0;

    logic [15:0] sw_sync_a, counter_a, sw_sync_t, counter_t;
    logic [4:0]  btn_db_a, btn_db_t;
    logic        mux_a, busy_a, done_a, tmo_a;
    logic        mux_t, busy_t, done_t, tmo_t;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       req;
        logic [3:0] port;
        logic       exp_done;
        logic       exp_mux;
    } vec_t;

    vec_t vecs [6];

    in_port_ctrl #(.DEBOUNCE_CYCLES(16'd4), .PRESCALE(16'd2), .BLOCKING_BTN(1'b1), .TIMEOUT(32'd0)) dut (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .btn_raw(btn_raw),
        .in_req(in_req), .port_sel(port_sel),
        .sw_sync(sw_sync_a), .btn_db(btn_db_a), .counter(counter_a),
        .in_mux_en(mux_a), .in_busy(busy_a), .in_done(done_a), .in_timeout(tmo_a)
    );

    in_port_ctrl #(.DEBOUNCE_CYCLES(16'd4), .PRESCALE(16'd1), .BLOCKING_BTN(1'b1), .TIMEOUT(32'd10)) dut_t (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .btn_raw(btn_raw),
        .in_req(in_req), .port_sel(port_sel),
        .sw_sync(sw_sync_t), .btn_db(btn_db_t), .counter(counter_t),
        .in_mux_en(mux_t), .in_busy(busy_t), .in_done(done_t), .in_timeout(tmo_t)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        in_req  = 1'b0;
        btn_raw = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd0,  1'b1, 1'b1};
        vecs[1] = '{1'b1, 4'd3,  1'b1, 1'b1};
        vecs[2] = '{1'b0, 4'd3,  1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'd4,  1'b1, 1'b0};
        vecs[4] = '{1'b1, 4'd7,  1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'd15, 1'b1, 1'b0};

        // Reset holds everything at zero, then switch sync latency.
        rst_n   = 1'b0;
        btn_raw = 5'h1F;
        sw_raw  = 16'hA5A5;
        repeat (3) tick();
        chk("rst_sw_sync", 32'(sw_sync_a), 32'h0);
        chk("rst_btn_db", 32'(btn_db_a), 32'h0);
        chk("rst_counter", 32'(counter_a), 32'h0);
        chk("rst_outs", {28'h0, mux_a, busy_a, done_a, tmo_a}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("sw_sync_1clk", 32'(sw_sync_a), 32'h0);
        tick();
        chk("sw_sync_2clk", 32'(sw_sync_a), 32'hA5A5);

        // Table of immediate reads.
        do_reset();
        for (int v = 0; v < 6; v++) begin
            in_req   = vecs[v].req;
            port_sel = vecs[v].port;
            tick();
            in_req = 1'b0;
            chk($sformatf("vec%0d_done", v), 32'(done_a), 32'(vecs[v].exp_done));
            chk($sformatf("vec%0d_mux", v), 32'(mux_a), 32'(vecs[v].exp_mux));
            chk($sformatf("vec%0d_busy", v), 32'(busy_a), 32'(vecs[v].exp_done));
            chk($sformatf("vec%0d_tmo", v), 32'(tmo_a), 32'h0);
            tick();
            chk($sformatf("vec%0d_idle", v), {30'h0, busy_a, done_a}, 32'h0);
        end

        // Debounce rejects 2-cycle toggles, accepts a steady level after 2+4 clocks.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = ~btn_raw[0];
            tick();
            chk("db_toggle_a", 32'(btn_db_a[0]), 32'h0);
            tick();
            chk("db_toggle_b", 32'(btn_db_a[0]), 32'h0);
        end
        btn_raw[0] = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk($sformatf("db_rise_%0d", j), 32'(btn_db_a[0]), 32'(j == 6));
        end

        // Blocking BTNR read waits for a press; counter keeps running meanwhile.
        do_reset();
        in_req   = 1'b1;
        port_sel = 4'd1;
        tick();
        in_req = 1'b0;
        chk("btnr_busy", 32'(busy_a), 32'h1);
        chk("btnr_nodone", 32'(done_a), 32'h0);
        repeat (9) begin
            tick();
            chk("btnr_wait", {30'h0, busy_a, done_a}, 32'h2);
        end
        chk("counter_in_wait", 32'(counter_a), 32'd5);
        btn_raw[3] = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk($sformatf("btnr_db_%0d", j), 32'(btn_db_a[3]), 32'(j == 6));
            chk("btnr_done_early", 32'(done_a), 32'h0);
        end
        tick();
        chk("btnr_done", 32'(done_a), 32'h1);
        chk("btnr_mux", 32'(mux_a), 32'h1);
        chk("btnr_tmo", 32'(tmo_a), 32'h0);
        tick();
        chk("btnr_after", {30'h0, busy_a, done_a}, 32'h0);
        // Flag was consumed: a second read waits again.
        in_req = 1'b1;
        tick();
        in_req = 1'b0;
        repeat (5) begin
            tick();
            chk("btnr2_wait", {30'h0, busy_a, done_a}, 32'h2);
        end
        btn_raw[3] = 1'b0;
        repeat (8) begin
            tick();
            chk("btnr2_release", 32'(done_a), 32'h0);
        end
        btn_raw[3] = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk("btnr2_pending", 32'(done_a), 32'h0);
        end
        tick();
        chk("btnr2_done", 32'(done_a), 32'h1);

        // Pre-latched BTNC press; in_req while busy is ignored.
        do_reset();
        btn_raw[0] = 1'b1;
        repeat (6) tick();
        chk("btnc_db", 32'(btn_db_a[0]), 32'h1);
        tick();
        in_req   = 1'b1;
        port_sel = 4'd2;
        tick();
        chk("btnc_done", 32'(done_a), 32'h1);
        chk("btnc_mux", 32'(mux_a), 32'h1);
        port_sel = 4'd3;
        tick();
        in_req = 1'b0;
        chk("busy_req_ignored", {30'h0, busy_a, done_a}, 32'h0);
        tick();
        chk("busy_req_nodone", 32'(done_a), 32'h0);
        // Flag consumed: next BTNC read waits; reset drops it.
        in_req   = 1'b1;
        port_sel = 4'd2;
        tick();
        in_req = 1'b0;
        chk("btnc2_wait", {30'h0, busy_a, done_a}, 32'h2);
        repeat (3) begin
            tick();
            chk("btnc2_hold", {30'h0, busy_a, done_a}, 32'h2);
        end
        rst_n = 1'b0;
        #1;
        chk("midwait_rst", {30'h0, busy_a, done_a}, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("midwait_nodone", {30'h0, busy_a, done_a}, 32'h0);
        end
        btn_raw = '0;

        // Timeout instance: BTNC wait ends on the 11th cycle with in_timeout.
        do_reset();
        in_req   = 1'b1;
        port_sel = 4'd2;
        for (int j = 1; j <= 11; j++) begin
            tick();
            in_req = 1'b0;
            chk($sformatf("tmo_done_%0d", j), 32'(done_t), 32'(j == 11));
            chk($sformatf("tmo_flag_%0d", j), 32'(tmo_t), 32'(j == 11));
        end
        chk("tmo_mux", 32'(mux_t), 32'h1);
        tick();
        chk("tmo_after", {29'h0, busy_t, done_t, tmo_t}, 32'h0);
        in_req   = 1'b1;
        port_sel = 4'd7;
        tick();
        in_req = 1'b0;
        chk("port7_done", 32'(done_t), 32'h1);
        chk("port7_mux", 32'(mux_t), 32'h0);
        chk("port7_tmo", 32'(tmo_t), 32'h0);

        // Counter wrap.
        do_reset();
        repeat (65535) tick();
        chk("cnt_ffff", 32'(counter_t), 32'hFFFF);
        chk("cnt_presc2", 32'(counter_a), 32'h7FFF);
        tick();
        chk("cnt_wrap", 32'(counter_t), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/in_port_ctrl.md
Name: in_port_ctrl

Overview:
- Sequences CPU IN instructions against the register-file input mux.
- Synchronises the switches, and synchronises and debounces the buttons.
- Keeps sticky press flags, so a button read can block until a press occurs.
- Runs the free-running counter port, drives the mux enable and stalls the CPU until the read completes.
- Sits between board I/O pins and the CPU datapath input mux.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: synchronised button level must differ from the stable level for this many consecutive clocks before the stable level is updated.
- PRESCALE, 16'd1: clocks per counter increment (minimum 1).
- BLOCKING_BTN, 1'b1: 1 = button-port IN waits for a press; 0 = immediate read.
- TIMEOUT, 32'd0: maximum clocks spent in WAIT_BTN; 0 = no timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw_raw  in  16  board switches (asynchronous)
- btn_raw  in  5  board buttons (asynchronous); [0]=BTNC, [3]=BTNR
- in_req  in  1  one-cycle pulse: CPU issued IN
- port_sel  in  4  port for this IN (0 SW, 1 BTNR, 2 BTNC, 3 counter, others = no port)
- sw_sync  out  16  synchronised switches, to mux
- btn_db  out  5  debounced button levels, to mux
- counter  out  16  free-running counter, to mux
- in_mux_en  out  1  mux selects port data this cycle
- in_busy  out  1  CPU stall
- in_done  out  1  one-cycle pulse: register write cycle
- in_timeout  out  1  high with in_done when the read ended by timeout

Behaviour:
- **Reset** (async, rst_n=0):
  - All outputs 0, synchroniser flops 0, debounce counters 0.
  - Press flags 0, prescaler 0, state IDLE.
- **Synchronisers:** two flops on sw_raw and btn_raw; sw_sync is the second stage (2-cycle latency).
- **Debounce, per button:**
  - While sync != btn_db[i], cnt[i] increments.
  - When cnt[i] reaches DEBOUNCE_CYCLES-1 and sync still differs, btn_db[i] <= sync and cnt[i] <= 0.
  - Any cycle with sync == btn_db[i] clears cnt[i].
- **Press flags:**
  - press[i] is set on a btn_db[i] 0->1 transition.
  - press[i] is cleared in the CAPTURE cycle of a read of that button's port.
  - A set and a clear in the same cycle leaves the flag set.
- **Counter:**
  - Prescaler counts 0..PRESCALE-1; counter increments when the prescaler wraps.
  - counter wraps 16'hFFFF -> 16'h0000.
  - The counter never stops, including during WAIT_BTN.
- **FSM states:** IDLE, WAIT_BTN, CAPTURE. in_busy = (state != IDLE).
- **IDLE:**
  - in_req with port 1 or 2, BLOCKING_BTN=1 and the corresponding press flag clear -> WAIT_BTN, with the port latched.
  - Any other in_req -> CAPTURE, with the port latched.
  - port_sel is sampled only in the in_req cycle.
- **WAIT_BTN:**
  - Press flag of the latched port set -> CAPTURE.
  - Otherwise, if TIMEOUT != 0 and the wait counter reaches TIMEOUT-1 -> CAPTURE with in_timeout=1.
  - The wait counter clears on entry.
- **CAPTURE (exactly one cycle):**
  - in_done=1.
  - in_mux_en=1 if the latched port <= 3, else 0, so the CPU writes alu_result.
  - Press flag of the latched button port is cleared.
  - Next state is IDLE.
- **Latency:**
  - Non-blocking read: in_req at cycle N, in_done at N+1.
  - Blocking read with flag already set: same, N+1.
  - Blocking read otherwise: in_done one cycle after the flag sets.
- in_req while in_busy=1 is ignored; there is no queue.
- port_sel 4..15 completes normally with in_mux_en=0.
- Reset asserted mid-wait returns to IDLE immediately; the pending read is dropped and no in_done is issued.
- in_timeout is 0 except in a timeout CAPTURE cycle.

Test Plan (DEBOUNCE_CYCLES=4, PRESCALE=2, TIMEOUT=0 unless stated):
- **Reset:** hold rst_n=0 with btn_raw=5'h1F and sw_raw=16'hA5A5 -> all outputs 0. Release reset -> sw_sync=16'hA5A5 after 2 clocks.
- **Debounce:** btn_raw[0] toggles every 2 clocks for 20 clocks, then holds 1 -> btn_db[0] stays 0 during toggling and rises exactly 2+4 clocks after the final edge.
- **Counter:** run 2*65536 clocks after reset -> counter reads 16'hFFFF then wraps to 16'h0000; in_req/port 3 at any time -> in_done next cycle with in_mux_en=1.
- **Blocking BTNR:**
  - in_req, port 1 with no press -> in_busy=1 and no in_done.
  - Press btn_raw[3] -> in_done and in_mux_en one cycle after btn_db[3] rises; press[3] cleared afterwards.
  - A second in_req, port 1 waits again.
- **Pre-latched press:** press btn_raw[0] while idle, then in_req port 2 -> in_done next cycle; an in_req pulse during busy is ignored (exactly one in_done).
- **Timeout / no-port:**
  - TIMEOUT=10, in_req port 2 with no press -> in_done and in_timeout at cycle 11.
  - in_req port 7 -> in_done next cycle with in_mux_en=0.
  - rst_n pulse during WAIT_BTN -> IDLE, no in_done.
